boxcar_decimator: RTL and testbench

BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

---
 rtl/boxcar_pkg.sv | 17 +
 rtl/boxcar_decimator_if.sv | 26 ++
 rtl/boxcar_skid_fifo.sv | 63 ++++++
 rtl/boxcar_decimator.sv | 80 ++++++++
 tb/tb_boxcar_decimator.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/boxcar_pkg.sv
// Shared types and constants for the boxcar decimation stage.
// Holds the decimator state encoding and the output FIFO sizing.
package boxcar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 9;
  localparam int DEFAULT_DECIM      = 2;
  localparam int FIFO_DEPTH         = 2;
  localparam int LEVEL_WIDTH        = $clog2(FIFO_DEPTH + 1);

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

endpackage

// File: rtl/boxcar_decimator_if.sv
// Sample-in / decimated-sample-out bundle for the boxcar decimator.
// master drives the upstream strobe, data and downstream ready; slave is the decimator.
interface boxcar_decimator_if #(
  parameter int DATA_WIDTH  = boxcar_pkg::DEFAULT_DATA_WIDTH,
  parameter int PHASE_WIDTH = $clog2(boxcar_pkg::DEFAULT_DECIM)
);
  logic                                     i_ce;
  logic                                     i_valid;
  logic signed [DATA_WIDTH-1:0]             i_data;
  logic                                     i_ready;
  logic                                     o_valid;
  logic signed [DATA_WIDTH-1:0]             o_data;
  logic [boxcar_pkg::LEVEL_WIDTH-1:0]       o_level;
  logic                                     o_overflow;
  logic [PHASE_WIDTH-1:0]                   o_phase;

  modport master (
    output i_ce, i_valid, i_data, i_ready,
    input  o_valid, o_data, o_level, o_overflow, o_phase
  );

  modport slave (
    input  i_ce, i_valid, i_data, i_ready,
    output o_valid, o_data, o_level, o_overflow, o_phase
  );
endinterface

// File: rtl/boxcar_skid_fifo.sv
// Two-entry registered FIFO; push visible on head one cycle later, no data path from input to head.
// Push+pop is legal at any level; a lone push while full is dropped and contents kept.
module boxcar_skid_fifo
  import boxcar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic signed [WIDTH-1:0] i_push_data,
  input  logic                    i_pop,
  output logic signed [WIDTH-1:0] o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [LEVEL_WIDTH-1:0]  o_level
);

  logic signed [WIDTH-1:0] head;
  logic signed [WIDTH-1:0] tail;
  logic [LEVEL_WIDTH-1:0]  level;
  logic                    do_pop;
  logic                    do_push;

  assign do_pop  = i_pop && (level != '0);
  assign do_push = i_push && ((level != FULL_LEVEL) || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (level == '0) head <= i_push_data;
          else             tail <= i_push_data;
          level <= level + LEVEL_WIDTH'(1);
        end
        2'b01: begin
          head  <= tail;
          level <= level - LEVEL_WIDTH'(1);
        end
        2'b11: begin
          // Level holds; at one entry the new sample replaces the leaving head.
          if (level == LEVEL_WIDTH'(1)) begin
            head <= i_push_data;
          end else begin
            head <= tail;
            tail <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = head;
  assign o_level = level;
  assign o_full  = (level == FULL_LEVEL);
  assign o_empty = (level == '0);

endmodule

// File: rtl/boxcar_decimator.sv
// Keeps every DECIM-th accepted sample of each valid run; output appears one cycle after its accept.
// Downstream stall buffers two samples in a FIFO, further pushes are dropped and flagged sticky.
module boxcar_decimator
  import boxcar_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DECIM       = DEFAULT_DECIM,
  parameter int PHASE_WIDTH = $clog2(DECIM)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  boxcar_decimator_if.slave bus
);

  localparam logic [PHASE_WIDTH-1:0] PHASE_MAX   = PHASE_WIDTH'(DECIM - 1);
  localparam logic [PHASE_WIDTH-1:0] PHASE_START = (DECIM == 1) ? '0 : PHASE_WIDTH'(1);

  state_t                 state;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   overflow;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign accept = bus.i_ce && bus.i_valid;
  // Phase is 0 in IDLE, so the first accept of a run is always pushed.
  assign push   = accept && (phase == '0);
  assign pop    = !fifo_empty && bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            phase <= PHASE_START;
          end
        end
        RUN: begin
          if (!bus.i_valid) begin
            state <= IDLE;
            phase <= '0;
          end else if (accept) begin
            phase <= (phase == PHASE_MAX) ? '0 : phase + PHASE_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  boxcar_skid_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (bus.i_data),
    .i_pop       (pop),
    .o_head      (bus.o_data),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (bus.o_level)
  );

  assign bus.o_valid    = !fifo_empty;
  assign bus.o_overflow = overflow;
  assign bus.o_phase    = phase;

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench: vector table on a DECIM=2 instance, hand sequence on a DECIM=4 instance.
module tb_boxcar_decimator;
  import boxcar_pkg::*;

  logic i_clk = 1'b0;
  logic rst2  = 1'b1;
  logic rst4  = 1'b1;
  always #5 i_clk = ~i_clk;

  boxcar_decimator_if #(.DATA_WIDTH(9), .PHASE_WIDTH(1)) b2 ();
  boxcar_decimator_if #(.DATA_WIDTH(9), .PHASE_WIDTH(2)) b4 ();

  boxcar_decimator #(.DATA_WIDTH(9), .DECIM(2), .PHASE_WIDTH(1)) u_dut2 (
    .i_clk(i_clk), .i_reset(rst2), .bus(b2.slave)
  );
  boxcar_decimator #(.DATA_WIDTH(9), .DECIM(4), .PHASE_WIDTH(2)) u_dut4 (
    .i_clk(i_clk), .i_reset(rst4), .bus(b4.slave)
  );

  typedef struct {
    logic rst;
    logic ce;
    logic vld;
    int   dat;
    logic rdy;
    logic ev;
    int   ed;
    int   el;
    logic eo;
    int   ep;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic rst, logic ce, logic vld, int dat, logic rdy,
                              logic ev, int ed, int el, logic eo, int ep);
    vec_t v;
    v.rst = rst; v.ce = ce; v.vld = vld; v.dat = dat; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  int got4[$];
  int exp4[4];

  task automatic step4(input logic ce, input logic vld, input int dat);
    b4.i_ce    = ce;
    b4.i_valid = vld;
    b4.i_data  = 9'(dat);
    b4.i_ready = 1'b1;
    @(posedge i_clk); #1;
    if (b4.o_valid) got4.push_back(int'(b4.o_data));
  endtask

  initial begin
    b2.i_ce = 0; b2.i_valid = 0; b2.i_data = '0; b2.i_ready = 0;
    b4.i_ce = 0; b4.i_valid = 0; b4.i_data = '0; b4.i_ready = 0;
    exp4 = '{0, 4, 100, 104};

    //          rst ce vld dat  rdy  ev  ed   el eo ep
    // reset state
    vq.push_back(mk(1, 1, 1,  33, 1,  0,   0, 0, 0, 0));
    // strobe without valid is not an accept
    vq.push_back(mk(0, 0, 1,  99, 1,  0,   0, 0, 0, 0));
    // decimation by 2: 10..15 -> 10,12,14
    vq.push_back(mk(0, 1, 1,  10, 1,  1,  10, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,  11, 1,  0,   0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1,  12, 1,  1,  12, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,  13, 1,  0,   0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1,  14, 1,  1,  14, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,  15, 1,  0,   0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,   0, 1,  0,   0, 0, 0, 0));
    // backpressure: 1..6 -> holds 1,3; push of 5 overflows
    vq.push_back(mk(0, 1, 1,   1, 0,  1,   1, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,   2, 0,  1,   1, 1, 0, 0));
    vq.push_back(mk(0, 1, 1,   3, 0,  1,   1, 2, 0, 1));
    vq.push_back(mk(0, 1, 1,   4, 0,  1,   1, 2, 0, 0));
    vq.push_back(mk(0, 1, 1,   5, 0,  1,   1, 2, 1, 1));
    vq.push_back(mk(0, 1, 1,   6, 0,  1,   1, 2, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 1,  1,   3, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,   0, 1,  0,   0, 0, 1, 0));
    vq.push_back(mk(1, 0, 0,   0, 0,  0,   0, 0, 0, 0));
    // push+pop at full: output order 1,3,5, no overflow
    vq.push_back(mk(0, 1, 1,   1, 0,  1,   1, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,   2, 0,  1,   1, 1, 0, 0));
    vq.push_back(mk(0, 1, 1,   3, 0,  1,   1, 2, 0, 1));
    vq.push_back(mk(0, 1, 1,   4, 0,  1,   1, 2, 0, 0));
    vq.push_back(mk(0, 1, 1,   5, 1,  1,   3, 2, 0, 1));
    vq.push_back(mk(0, 1, 1,   6, 1,  1,   5, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,   0, 1,  0,   0, 0, 0, 0));
    // reset mid-run with full FIFO and overflow set; reset wins over accept
    vq.push_back(mk(0, 1, 1,   1, 0,  1,   1, 1, 0, 1));
    vq.push_back(mk(0, 1, 1,   2, 0,  1,   1, 1, 0, 0));
    vq.push_back(mk(0, 1, 1,   3, 0,  1,   1, 2, 0, 1));
    vq.push_back(mk(0, 1, 1,   4, 0,  1,   1, 2, 0, 0));
    vq.push_back(mk(0, 1, 1,   5, 0,  1,   1, 2, 1, 1));
    vq.push_back(mk(1, 1, 1,   6, 1,  0,   0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1,  -7, 0,  1,  -7, 1, 0, 1));
    vq.push_back(mk(0, 0, 0,   0, 1,  0,   0, 0, 0, 0));
    // signed extremes pass bit-exact
    vq.push_back(mk(0, 1, 1,-256, 1,  1,-256, 1, 0, 1));
    vq.push_back(mk(0, 1, 1, 255, 1,  0,   0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,   0, 1,  0,   0, 0, 0, 0));

    foreach (vq[i]) begin
      rst2       = vq[i].rst;
      b2.i_ce    = vq[i].ce;
      b2.i_valid = vq[i].vld;
      b2.i_data  = 9'(vq[i].dat);
      b2.i_ready = vq[i].rdy;
      @(posedge i_clk); #1;
      chk($sformatf("v%0d.valid", i), int'(b2.o_valid), int'(vq[i].ev));
      chk($sformatf("v%0d.level", i), int'(b2.o_level), vq[i].el);
      chk($sformatf("v%0d.ovf", i), int'(b2.o_overflow), int'(vq[i].eo));
      chk($sformatf("v%0d.phase", i), int'(b2.o_phase), vq[i].ep);
      if (vq[i].ev || vq[i].rst)
        chk($sformatf("v%0d.data", i), int'(b2.o_data), vq[i].ed);
    end
    rst2 = 1'b0;

    // DECIM=4 realignment: 0..5, one invalid cycle, 100..104 -> 0,4,100,104
    @(posedge i_clk); #1;
    rst4 = 1'b0;
    for (int k = 0; k < 6; k++) step4(1'b1, 1'b1, k);
    step4(1'b1, 1'b0, 77);
    chk("d4.phase_after_drop", int'(b4.o_phase), 0);
    for (int k = 0; k < 5; k++) step4(1'b1, 1'b1, 100 + k);
    for (int k = 0; k < 3; k++) step4(1'b0, 1'b0, 0);
    chk("d4.count", got4.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("d4.out%0d", k), (k < got4.size()) ? got4[k] : -999, exp4[k]);
    chk("d4.ovf", int'(b4.o_overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
